// File: rtl/adc_sar_pkg.sv
// Shared definitions for the SAR ADC controller: state encoding, default width, comparator polarity.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package adc_sar_pkg;

  // Default conversion resolution; matches the row/col decoder data_in width.
  localparam int DATA_W_DEF = 10;

  // Comparator level that means "input above DAC level, keep the trial bit".
  localparam logic COMP_KEEP = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SAMPLE = 2'd1,
    S_CONV   = 2'd2,
    S_DONE   = 2'd3
  } sar_state_t;

endpackage

// File: rtl/adc_sar_bit_register.sv
// Successive-approximation register: one-hot bit pointer plus resolved bits (sar_reg).
// Latency: state updates on the clock edge; trial/sar outputs show the value being loaded at that edge.
// Backpressure: none; the controller drives clear/step every cycle.
module adc_sar_bit_register
  import adc_sar_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_in,
  input  logic              step_in,
  input  logic              comp_in,
  output logic [DATA_W-1:0] trial_code_out,
  output logic [DATA_W-1:0] sar_code_out,
  output logic              last_bit_out
);

  localparam logic [DATA_W-1:0] MSB_ONEHOT = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] ptr_q, ptr_d;
  logic [DATA_W-1:0] sar_q, sar_d;

  // Next pointer/result: clear arms the MSB trial, step resolves the current bit and moves down.
  always_comb begin
    ptr_d = ptr_q;
    sar_d = sar_q;
    if (clear_in) begin
      ptr_d = MSB_ONEHOT;
      sar_d = '0;
    end else if (step_in) begin
      if (comp_in == COMP_KEEP) begin
        sar_d = sar_q | ptr_q;
      end
      ptr_d = ptr_q >> 1;
    end
  end

  // Pointer and result registers; a partial search is discarded on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      sar_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      sar_q <= sar_d;
    end
  end

  // Outputs are the values being loaded so the controller can register the DAC code without a bubble.
  // After the LSB step the pointer is empty, so the trial code equals the final result.
  assign trial_code_out = sar_d | ptr_d;
  assign sar_code_out   = sar_d;
  assign last_bit_out   = ptr_q[0];

endmodule

// File: rtl/adc_sar_controller.sv
// SAR ADC controller: sample -> binary search -> result, with optional oversampling (ADC_SAR_OVERSAMPLE_EN).
// Latency: start accepted at edge T -> valid_out in cycle T+SAMPLE_CYCLES+DATA_W+1 (x2^OSR_LOG2 conversions when oversampling).
// Backpressure: none; start_in is only looked at in IDLE/DONE, with no queueing.
module adc_sar_controller
  import adc_sar_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SAMPLE_CYCLES = 2,
  parameter int OSR_LOG2      = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start_in,
  input  logic                       comp_in,
  output logic                       sample_out,
  output logic                       comp_en_out,
  output logic [DATA_W-1:0]          dac_code_out,
  output logic                       busy_out,
  output logic                       valid_out,
  output logic [DATA_W+OSR_LOG2-1:0] result_out
);

  localparam int RES_W = DATA_W + OSR_LOG2;
  localparam logic [3:0] SAMP_LAST = 4'(SAMPLE_CYCLES - 1);

  sar_state_t state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;

  logic              sar_clear, sar_step, sar_last;
  logic [DATA_W-1:0] trial_code, sar_code;

  // All outputs are flops so the decoder sees at most one code change per cycle.
  logic              sample_q, sample_d;
  logic              comp_en_q, comp_en_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] dac_q, dac_d;
  logic [RES_W-1:0]  result_q, result_d;

`ifdef ADC_SAR_OVERSAMPLE_EN
  localparam logic [OSR_LOG2:0] CONV_ALL  = '1;
  localparam logic [OSR_LOG2:0] CONV_LAST = CONV_ALL >> 1;

  logic                start_acc, conv_end;
  logic [OSR_LOG2:0]   conv_cnt_q, conv_cnt_d;
  logic [RES_W-1:0]    acc_q, acc_d;
`endif

  adc_sar_bit_register #(
    .DATA_W(DATA_W)
  ) u_bit_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear_in      (sar_clear),
    .step_in       (sar_step),
    .comp_in       (comp_in),
    .trial_code_out(trial_code),
    .sar_code_out  (sar_code),
    .last_bit_out  (sar_last)
  );

  // Next-state logic and bit-register control.
  always_comb begin
    state_d    = state_q;
    samp_cnt_d = samp_cnt_q;
    sar_clear  = 1'b0;
    sar_step   = 1'b0;
`ifdef ADC_SAR_OVERSAMPLE_EN
    start_acc  = 1'b0;
    conv_end   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        sar_clear = 1'b1;
        if (start_in) begin
          state_d    = S_SAMPLE;
          samp_cnt_d = '0;
`ifdef ADC_SAR_OVERSAMPLE_EN
          start_acc  = 1'b1;
`endif
        end
      end
      S_SAMPLE: begin
        sar_clear = 1'b1;
        if (samp_cnt_q == SAMP_LAST) begin
          state_d    = S_CONV;
          samp_cnt_d = '0;
        end else begin
          samp_cnt_d = samp_cnt_q + 4'd1;
        end
      end
      S_CONV: begin
        sar_step = 1'b1;
        if (sar_last) begin
`ifdef ADC_SAR_OVERSAMPLE_EN
          conv_end = 1'b1;
          if (conv_cnt_q == CONV_LAST) begin
            state_d = S_DONE;
          end else begin
            state_d    = S_SAMPLE;
            samp_cnt_d = '0;
          end
`else
          state_d = S_DONE;
`endif
        end
      end
      S_DONE: begin
        sar_clear = 1'b1;
        if (start_in) begin
          state_d    = S_SAMPLE;
          samp_cnt_d = '0;
`ifdef ADC_SAR_OVERSAMPLE_EN
          start_acc  = 1'b1;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef ADC_SAR_OVERSAMPLE_EN
  // Accumulator and conversion counter: cleared on an accepted start, summed at the end of each search.
  always_comb begin
    acc_d      = acc_q;
    conv_cnt_d = conv_cnt_q;
    if (start_acc) begin
      acc_d      = '0;
      conv_cnt_d = '0;
    end else if (conv_end) begin
      acc_d      = acc_q + RES_W'(sar_code);
      conv_cnt_d = conv_cnt_q + 1'b1;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      conv_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      conv_cnt_q <= conv_cnt_d;
    end
  end
`endif

  // Output values decoded from the state being entered, so they are registered alongside it.
  always_comb begin
    sample_d  = (state_d == S_SAMPLE);
    comp_en_d = (state_d == S_CONV);
    busy_d    = (state_d == S_SAMPLE) || (state_d == S_CONV);
    valid_d   = (state_d == S_DONE);
    dac_d     = ((state_d == S_CONV) || (state_d == S_DONE)) ? trial_code : '0;
    result_d  = result_q;
    if (valid_d) begin
`ifdef ADC_SAR_OVERSAMPLE_EN
      result_d = acc_d;
`else
      result_d = RES_W'(sar_code);
`endif
    end
  end

  // State, sample counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      samp_cnt_q <= '0;
      sample_q   <= 1'b0;
      comp_en_q  <= 1'b0;
      busy_q     <= 1'b0;
      valid_q    <= 1'b0;
      dac_q      <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      samp_cnt_q <= samp_cnt_d;
      sample_q   <= sample_d;
      comp_en_q  <= comp_en_d;
      busy_q     <= busy_d;
      valid_q    <= valid_d;
      dac_q      <= dac_d;
      result_q   <= result_d;
    end
  end

  assign sample_out   = sample_q;
  assign comp_en_out  = comp_en_q;
  assign busy_out     = busy_q;
  assign valid_out    = valid_q;
  assign dac_code_out = dac_q;
  assign result_out   = result_q;

endmodule

// File: tb/tb_adc_sar_controller.sv
// Self-checking bench for adc_sar_controller with a comparator model and a result scoreboard.
// Latency: expects valid_out LAT cycles after an accepted start (13, or 49 with ADC_SAR_OVERSAMPLE_EN).
// Backpressure: none; exercises back-to-back starts and ignored starts during conversion.
module tb_adc_sar_controller;

  localparam int DW = 10;
  localparam int RW = 12;
`ifdef ADC_SAR_OVERSAMPLE_EN
  localparam int NCONV = 4;
`else
  localparam int NCONV = 1;
`endif
  localparam int LAT = NCONV * (2 + DW) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start_in;
  logic          comp_in;
  logic          sample_out;
  logic          comp_en_out;
  logic [DW-1:0] dac_code_out;
  logic          busy_out;
  logic          valid_out;
  logic [RW-1:0] result_out;

  int            comp_mode;  // 0: model vin >= dac, 1: always 1, 2: always 0
  logic [DW-1:0] vin;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [RW-1:0] exp_q[$];
  logic [DW-1:0] dac_log[$];

  adc_sar_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_in    (start_in),
    .comp_in     (comp_in),
    .sample_out  (sample_out),
    .comp_en_out (comp_en_out),
    .dac_code_out(dac_code_out),
    .busy_out    (busy_out),
    .valid_out   (valid_out),
    .result_out  (result_out)
  );

  always #5 clk = ~clk;

  // Comparator model: input above the DAC level means keep the trial bit.
  always @* begin
    comp_in = 1'b0;
    case (comp_mode)
      1:       comp_in = 1'b1;
      2:       comp_in = 1'b0;
      default: comp_in = (vin >= dac_code_out);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One start pulse; push expected result, wait bounded for valid_out, check latency and result.
  task automatic run_conv(input int mode, input logic [DW-1:0] v, input string tag);
    logic [RW-1:0] e;
    int  cyc;
    int  comp_cycles;
    bit  seen;
    comp_mode = mode;
    vin       = v;
    if (mode == 1)      e = RW'(NCONV * 1023);
    else if (mode == 2) e = '0;
    else                e = RW'(NCONV * int'(v));
    exp_q.push_back(e);
    @(negedge clk) start_in = 1'b1;
    @(negedge clk) start_in = 1'b0;
    cyc = 1;
    comp_cycles = 0;
    seen = 0;
    while (!seen && cyc <= LAT + 20) begin
      if (comp_en_out) begin
        comp_cycles++;
        if (dac_log.size() < DW) dac_log.push_back(dac_code_out);
      end
      if (valid_out) begin
        seen = 1;
        chk({tag, " latency"}, cyc, LAT);
        chk({tag, " result"}, result_out, exp_q.pop_front());
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      chk({tag, " timeout"}, 32'(seen), 1);
      void'(exp_q.pop_front());
    end
    chk({tag, " comp_en cycles"}, comp_cycles, NCONV * DW);
    @(negedge clk);
    chk({tag, " valid one-shot"}, valid_out, 0);
  endtask

  initial begin
    logic [DW-1:0] dac_exp [DW];
    logic [RW-1:0] e;
    int vcyc [$];
    int cyc;
    int idle_cnt;
    int vcount;

    dac_exp = '{10'h200, 10'h300, 10'h280, 10'h2C0, 10'h2A0,
                10'h2B0, 10'h2A8, 10'h2A4, 10'h2A6, 10'h2A5};

    rst_n = 1'b0;
    start_in = 1'b0;
    comp_mode = 0;
    vin = '0;

    #1;
    chk("reset busy", busy_out, 0);
    chk("reset valid", valid_out, 0);
    chk("reset sample", sample_out, 0);
    chk("reset comp_en", comp_en_out, 0);
    chk("reset dac", dac_code_out, 0);
    chk("reset result", result_out, 0);

    #20;
    @(negedge clk) rst_n = 1'b1;

    // Binary search trace for vin = 0x2A5.
    dac_log.delete();
    run_conv(0, 10'h2A5, "vin2a5");
    chk("dac trace length", dac_log.size(), DW);
    for (int i = 0; i < DW; i++) begin
      if (i < dac_log.size()) chk($sformatf("dac trace %0d", i), dac_log[i], dac_exp[i]);
    end

    run_conv(1, '0, "comp ones");
    run_conv(2, '0, "comp zeros");
    run_conv(0, 10'h155, "vin155");

    // Result must hold until the next valid_out.
    repeat (5) @(negedge clk);
    chk("result hold", result_out, RW'(NCONV * 'h155));
    chk("idle busy", busy_out, 0);

    // start_in held high: back-to-back conversions with no IDLE gap.
    comp_mode = 0;
    vin = 10'h0F0;
    e = RW'(NCONV * 'h0F0);
    @(negedge clk) start_in = 1'b1;
    @(negedge clk);
    cyc = 1;
    idle_cnt = 0;
    vcyc.delete();
    while (vcyc.size() < 3 && cyc <= 4 * LAT + 50) begin
      if (valid_out) begin
        vcyc.push_back(cyc);
        exp_q.push_back(e);
        chk("b2b result", result_out, exp_q.pop_front());
        if (vcyc.size() == 3) start_in = 1'b0;
      end else if (!busy_out) begin
        idle_cnt++;
      end
      if (vcyc.size() < 3) begin
        @(negedge clk);
        cyc++;
      end
    end
    start_in = 1'b0;
    chk("b2b valid count", vcyc.size(), 3);
    if (vcyc.size() == 3) begin
      chk("b2b first latency", vcyc[0], LAT);
      chk("b2b period 1", vcyc[1] - vcyc[0], LAT);
      chk("b2b period 2", vcyc[2] - vcyc[1], LAT);
    end
    chk("b2b idle cycles", idle_cnt, 0);
    repeat (2) @(negedge clk);
    chk("b2b drained", busy_out, 0);

    // A start pulse during CONV must be ignored.
    @(negedge clk) start_in = 1'b1;
    @(negedge clk) start_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("ignored start in conv", comp_en_out, 1);
    start_in = 1'b1;
    @(negedge clk) start_in = 1'b0;
    vcount = 0;
    for (int i = 0; i < 2 * LAT + 10; i++) begin
      if (valid_out) vcount++;
      @(negedge clk);
    end
    chk("ignored start valid count", vcount, 1);

    // Asynchronous reset in the middle of CONV at bit k=5.
    comp_mode = 0;
    vin = 10'h2A5;
    @(negedge clk) start_in = 1'b1;
    @(negedge clk) start_in = 1'b0;
    repeat (6) @(negedge clk);
    chk("midconv comp_en", comp_en_out, 1);
    chk("midconv dac k5", dac_code_out, 10'h2A0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst state", 32'(dut.state_q), 0);
    chk("async rst busy", busy_out, 0);
    chk("async rst sample", sample_out, 0);
    chk("async rst comp_en", comp_en_out, 0);
    chk("async rst valid", valid_out, 0);
    chk("async rst result", result_out, 0);
    chk("async rst dac", dac_code_out, 0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Recovery after reset.
    run_conv(0, 10'h2A5, "after reset");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
